wb_retire_arbiter: RTL and testbench

- Parametrised write-back/retire stage for the RISC-V pipeline.
- Accepts results from NUM_CH producer channels (e.g. ALU, load, CSR/system), each with its own small FIFO.
- Arbitrates round-robin onto a single register-file write port.
- Sequences ECALL instructions through a request/acknowledge handshake with a minimum-duration counter.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_chan_fifo.sv | 40 ++++
 rtl/wb_retire_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_retire_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and helpers for the write-back/retire stage
package wb_pkg;
  typedef enum logic [1:0] {
    K_NOWRITE = 2'b00,
    K_DATA    = 2'b01,
    K_LINK    = 2'b10,
    K_ECALL   = 2'b11
  } wb_kind_e;
  typedef enum logic [1:0] {S_RUN, S_ECALL_REQ, S_ECALL_WR} wb_state_e;
  localparam int WB_XLEN = 64;
  // Canonical entry layout; FIFOs store the same field order as a flat vector
  typedef struct packed {
    wb_kind_e            kind;
    logic [WB_XLEN-1:0]  pc;
    logic [WB_XLEN-1:0]  data;
    logic [4:0]          dest;
  } wb_entry_t;
  function automatic logic kind_writes(wb_kind_e k, logic [4:0] dest);
    return (k == K_DATA || k == K_LINK) && dest != 5'd0;
  endfunction
endpackage

// File: rtl/wb_chan_fifo.sv
// wb_chan_fifo: per-channel result FIFO with wrap-bit pointers and synchronous flush
module wb_chan_fifo #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [2*XLEN+6:0] din,
  output logic [2*XLEN+6:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]       r_wp, r_rp;
  logic [2*XLEN+6:0] r_mem [DEPTH];
  logic              w_push, w_pop;
  assign empty  = r_wp == r_rp;
  assign full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign dout   = r_mem[r_rp[AW-1:0]];
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/wb_retire_arbiter.sv
// wb_retire_arbiter: round-robin retire of per-channel results onto one RF write port, with ECALL handshake
module wb_retire_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN             = 64,
  parameter int NUM_CH           = 3,
  parameter int DEPTH            = 4,
  parameter int ECALL_MIN_CYCLES = 4,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      in_valid,
  output logic [NUM_CH-1:0]      in_ready,
  input  logic [NUM_CH*5-1:0]    in_dest,
  input  logic [NUM_CH*XLEN-1:0] in_data,
  input  logic [NUM_CH*XLEN-1:0] in_pc,
  input  logic [NUM_CH*2-1:0]    in_kind,
  input  logic                   flush,
  output logic                   rf_wen,
  output logic [4:0]             rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  output logic                   retire_valid,
  output logic [XLEN-1:0]        retire_pc,
  output logic [CW-1:0]          retire_ch,
  output logic                   ecall_req,
  output logic [XLEN-1:0]        ecall_pc,
  input  logic                   ecall_ack,
  input  logic [XLEN-1:0]        ecall_result,
  output logic                   busy
);
  localparam int W  = 2*XLEN+7;
  localparam int KW = $clog2(ECALL_MIN_CYCLES+1);
  logic [W-1:0]      w_dout [NUM_CH];
  logic [NUM_CH-1:0] w_empty, w_full, w_pop;
  logic [W-1:0]      w_head;
  wb_kind_e          w_kind;
  logic [4:0]        w_hdest;
  logic [XLEN-1:0]   w_hdata, w_hpc;
  wb_state_e         r_state, w_state;
  logic [CW-1:0]     r_last, w_gnt, r_ec_ch, w_ec_ch, r_rch, w_rch;
  logic              w_gnt_valid, w_pop_en;
  logic [KW-1:0]     r_cnt, w_cnt;
  logic [4:0]        r_ec_dest, w_ec_dest, r_waddr, w_waddr;
  logic [XLEN-1:0]   r_ec_pc, w_ec_pc, r_wdata, w_wdata, r_rpc, w_rpc;
  logic              r_wen, w_wen, r_valid, w_valid;
  genvar g;
  for (g = 0; g < NUM_CH; g++) begin : g_ch
    wb_chan_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid[g]),
      .pop   (w_pop[g]),
      .flush (flush),
      .din   ({in_kind[g*2 +: 2], in_pc[g*XLEN +: XLEN], in_data[g*XLEN +: XLEN], in_dest[g*5 +: 5]}),
      .dout  (w_dout[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
    assign w_pop[g] = w_pop_en && (w_gnt == CW'(g));
  end
  // Walk downward so the channel nearest after r_last is the one left standing
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (!w_empty[(int'(r_last) + i) % NUM_CH]) begin
        w_gnt_valid = 1'b1;
        w_gnt       = CW'((int'(r_last) + i) % NUM_CH);
      end
    end
  end
  assign w_head  = w_dout[w_gnt];
  assign w_kind  = wb_kind_e'(w_head[W-1:W-2]);
  assign w_hpc   = w_head[2*XLEN+4:XLEN+5];
  assign w_hdata = w_head[XLEN+4:5];
  assign w_hdest = w_head[4:0];
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_ec_dest = r_ec_dest;
    w_ec_pc   = r_ec_pc;
    w_ec_ch   = r_ec_ch;
    w_wen     = 1'b0;
    w_valid   = 1'b0;
    w_waddr   = r_waddr;
    w_wdata   = r_wdata;
    w_rpc     = r_rpc;
    w_rch     = r_rch;
    w_pop_en  = (r_state == S_RUN) && w_gnt_valid && !flush;
    case (r_state)
      S_RUN: begin
        if (w_pop_en && w_kind == K_ECALL) begin
          w_state   = S_ECALL_REQ;
          w_cnt     = KW'(1);
          w_ec_dest = w_hdest;
          w_ec_pc   = w_hpc;
          w_ec_ch   = w_gnt;
        end else if (w_pop_en) begin
          w_valid = 1'b1;
          w_wen   = kind_writes(w_kind, w_hdest);
          w_waddr = w_hdest;
          w_wdata = (w_kind == K_LINK) ? w_hpc + XLEN'(4) : w_hdata;
          w_rpc   = w_hpc;
          w_rch   = w_gnt;
        end
      end
      S_ECALL_REQ: begin
        if (r_cnt < KW'(ECALL_MIN_CYCLES)) begin
          w_cnt = r_cnt + 1'b1;
        end else if (ecall_ack) begin
          w_state = S_ECALL_WR;
          w_valid = 1'b1;
          w_wen   = r_ec_dest != 5'd0;
          w_waddr = r_ec_dest;
          w_wdata = ecall_result;
          w_rpc   = r_ec_pc;
          w_rch   = r_ec_ch;
        end
      end
      default: begin
        w_state = S_RUN;
        w_cnt   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_last    <= '0;
      r_ec_dest <= '0;
      r_ec_pc   <= '0;
      r_ec_ch   <= '0;
      r_wen     <= 1'b0;
      r_valid   <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_rpc     <= '0;
      r_rch     <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_ec_dest <= w_ec_dest;
      r_ec_pc   <= w_ec_pc;
      r_ec_ch   <= w_ec_ch;
      r_wen     <= w_wen;
      r_valid   <= w_valid;
      r_waddr   <= w_waddr;
      r_wdata   <= w_wdata;
      r_rpc     <= w_rpc;
      r_rch     <= w_rch;
      if (w_pop_en) r_last <= w_gnt;
    end
  end
  assign in_ready     = ~w_full;
  assign rf_wen       = r_wen;
  assign rf_waddr     = r_waddr;
  assign rf_wdata     = r_wdata;
  assign retire_valid = r_valid;
  assign retire_pc    = r_rpc;
  assign retire_ch    = r_rch;
  assign ecall_req    = r_state == S_ECALL_REQ;
  assign ecall_pc     = r_ec_pc;
  assign busy         = !(&w_empty) || (r_state != S_RUN);
endmodule

// File: tb/tb_wb_retire_arbiter.sv
// tb_wb_retire_arbiter: directed self-checking bench for the retire arbiter
module tb_wb_retire_arbiter;
  logic         clk, reset;
  logic [2:0]   in_valid, in_ready;
  logic [14:0]  in_dest;
  logic [191:0] in_data, in_pc;
  logic [5:0]   in_kind;
  logic         flush, rf_wen, retire_valid, ecall_req, ecall_ack, busy;
  logic [4:0]   rf_waddr;
  logic [63:0]  rf_wdata, retire_pc, ecall_pc, ecall_result;
  logic [1:0]   retire_ch;
  int checks = 0;
  int errors = 0;
  int mlast, nret, tot;
  int mcnt[3], pend[3], popped[3], sent[3];

  wb_retire_arbiter #(.XLEN(64), .NUM_CH(3), .DEPTH(4), .ECALL_MIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
    .in_data(in_data), .in_pc(in_pc), .in_kind(in_kind), .flush(flush), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_ch(retire_ch), .ecall_req(ecall_req), .ecall_pc(ecall_pc), .ecall_ack(ecall_ack),
    .ecall_result(ecall_result), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input int c, input logic [1:0] k, input logic [4:0] d, input logic [63:0] dat, input logic [63:0] pc);
    in_valid[c] = 1'b1;
    in_kind[c*2 +: 2] = k;
    in_dest[c*5 +: 5] = d;
    in_data[c*64 +: 64] = dat;
    in_pc[c*64 +: 64] = pc;
  endtask

  task automatic one(input int c, input logic [1:0] k, input logic [4:0] d, input logic [63:0] dat,
                     input logic [63:0] pc, input logic ewen, input logic [63:0] ewd);
    drive(c, k, d, dat, pc);
    tick();
    in_valid = '0;
    chk("early_valid", 64'(retire_valid), 64'(0));
    tick();
    chk("valid", 64'(retire_valid), 64'(1));
    chk("wen", 64'(rf_wen), 64'(ewen));
    chk("waddr", 64'(rf_waddr), 64'(d));
    chk("ch", 64'(retire_ch), 64'(c));
    chk("rpc", retire_pc, pc);
    if (ewen) chk("wdata", rf_wdata, ewd);
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = '0; in_dest = '0; in_data = '0; in_pc = '0; in_kind = '0;
    flush = 1'b0; ecall_ack = 1'b0; ecall_result = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_wen", 64'(rf_wen), 64'(0));
    chk("rst_valid", 64'(retire_valid), 64'(0));
    chk("rst_req", 64'(ecall_req), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(3'b111));
    chk("rst_busy", 64'(busy), 64'(0));
    tick();
    reset = 1'b1;

    one(0, 2'b01, 5'd5, 64'h1234, 64'h100, 1'b1, 64'h1234);
    one(1, 2'b10, 5'd1, 64'h0, 64'h8000_0000, 1'b1, 64'h8000_0004);
    one(2, 2'b10, 5'd0, 64'h0, 64'h300, 1'b0, 64'h0);
    one(0, 2'b01, 5'd0, 64'h77, 64'h400, 1'b0, 64'h0);
    one(1, 2'b00, 5'd7, 64'h99, 64'h500, 1'b0, 64'h0);
    one(2, 2'b10, 5'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h0);

    // all three channels offered every cycle; scoreboard tracks queue depths and order
    mlast = 2; nret = 0;
    for (int c = 0; c < 3; c++) begin
      mcnt[c] = 0; pend[c] = 0; popped[c] = 0; sent[c] = 0;
    end
    for (int k = 0; k < 50; k++) begin
      int gch;
      gch = -1;
      for (int i = 1; i <= 3; i++)
        if (gch < 0 && mcnt[(mlast + i) % 3] > 0) gch = (mlast + i) % 3;
      chk("rr_valid", 64'(retire_valid), 64'(gch >= 0));
      if (retire_valid) nret++;
      if (gch >= 0) begin
        chk("rr_ch", 64'(retire_ch), 64'(gch));
        chk("rr_data", rf_wdata, 64'(gch*256 + popped[gch]));
        chk("rr_wen", 64'(rf_wen), 64'(1));
        popped[gch]++;
        mcnt[gch]--;
        mlast = gch;
      end
      for (int c = 0; c < 3; c++) mcnt[c] += pend[c];
      chk("rr_ready", 64'(in_ready), 64'({mcnt[2] != 4, mcnt[1] != 4, mcnt[0] != 4}));
      in_valid = '0;
      for (int c = 0; c < 3; c++) begin
        pend[c] = 0;
        if (k < 12) begin
          drive(c, 2'b01, 5'(c + 1), 64'(c*256 + sent[c]), 64'(c*4096 + sent[c]*4));
          pend[c] = (mcnt[c] != 4) ? 1 : 0;
          sent[c] += pend[c];
        end
      end
      tick();
    end
    tot = sent[0] + sent[1] + sent[2];
    chk("rr_count", 64'(nret), 64'(tot));
    chk("rr_busy", 64'(busy), 64'(0));

    // ECALL with ack held high from the start
    ecall_ack = 1'b1; ecall_result = 64'hDEAD_BEEF_0000_0011;
    drive(0, 2'b11, 5'd10, 64'h0, 64'h2000);
    tick();
    in_valid = '0;
    drive(1, 2'b01, 5'd6, 64'h66, 64'h2100);
    tick();
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      chk("ec_req", 64'(ecall_req), 64'(1));
      chk("ec_hold", 64'(retire_valid), 64'(0));
      if (i == 0) chk("ec_pc", ecall_pc, 64'h2000);
      tick();
    end
    chk("ec_req_drop", 64'(ecall_req), 64'(0));
    chk("ec_valid", 64'(retire_valid), 64'(1));
    chk("ec_wen", 64'(rf_wen), 64'(1));
    chk("ec_waddr", 64'(rf_waddr), 64'(10));
    chk("ec_wdata", rf_wdata, 64'hDEAD_BEEF_0000_0011);
    chk("ec_ch", 64'(retire_ch), 64'(0));
    chk("ec_rpc", retire_pc, 64'h2000);
    ecall_ack = 1'b0;
    tick();
    chk("ec_gap", 64'(retire_valid), 64'(0));
    tick();
    chk("ec_next_valid", 64'(retire_valid), 64'(1));
    chk("ec_next_ch", 64'(retire_ch), 64'(1));
    chk("ec_next_data", rf_wdata, 64'h66);
    tick();

    // ECALL pending while ch1 fills, then flush as the ECALL completes
    ecall_result = 64'h77;
    drive(0, 2'b11, 5'd3, 64'h0, 64'h3000);
    tick();
    in_valid = '0;
    drive(1, 2'b01, 5'd7, 64'hA1, 64'h3100);
    tick();
    drive(1, 2'b01, 5'd7, 64'hA2, 64'h3104);
    tick();
    drive(1, 2'b01, 5'd7, 64'hA3, 64'h3108);
    tick();
    in_valid = '0;
    chk("fl_ready", 64'(in_ready), 64'(3'b111));
    chk("fl_busy", 64'(busy), 64'(1));
    chk("fl_req", 64'(ecall_req), 64'(1));
    tick();
    ecall_ack = 1'b1;
    tick();
    chk("fl_ec_wen", 64'(rf_wen), 64'(1));
    chk("fl_ec_waddr", 64'(rf_waddr), 64'(3));
    chk("fl_ec_wdata", rf_wdata, 64'h77);
    ecall_ack = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_idle", 64'(busy), 64'(0));
    chk("fl_none0", 64'(retire_valid), 64'(0));
    tick();
    chk("fl_none1", 64'(retire_valid), 64'(0));
    tick();
    chk("fl_none2", 64'(retire_valid), 64'(0));

    // flush coinciding with a pop and an enqueue
    drive(2, 2'b01, 5'd8, 64'h88, 64'h3200);
    tick();
    in_valid = '0;
    flush = 1'b1;
    drive(0, 2'b01, 5'd9, 64'h99, 64'h3300);
    tick();
    flush = 1'b0;
    in_valid = '0;
    chk("fp_valid0", 64'(retire_valid), 64'(0));
    chk("fp_busy", 64'(busy), 64'(0));
    tick();
    chk("fp_valid1", 64'(retire_valid), 64'(0));

    // reset while ecall_req is up
    drive(0, 2'b11, 5'd4, 64'h0, 64'h4000);
    tick();
    in_valid = '0;
    tick();
    chk("mr_req", 64'(ecall_req), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("mr_req_drop", 64'(ecall_req), 64'(0));
    chk("mr_ready", 64'(in_ready), 64'(3'b111));
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_valid", 64'(retire_valid), 64'(0));
    tick();
    reset = 1'b1;
    one(2, 2'b01, 5'd9, 64'h55, 64'h5000, 1'b1, 64'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
